fft_input_loader: RTL and testbench

Input stage of the pipelined FFT. Accepts a complex sample stream with a valid/ready handshake and writes each N-point frame into one of two ping-pong banks of the stage-1 sample RAM. Addresses are bit-reversed or natural order, selected by a compile-time macro. Signals a completed frame to the downstream butterfly-address controller and holds that bank until the controller releases it.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_bitrev.sv | 18 +
 rtl/fft_input_loader.sv | 124 ++++++++++++
 tb/tb_fft_input_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, loader state encoding and the bit-reversal helper for the FFT input stage.
package fft_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_SIZE   = 4;
    localparam int FFT_DATA_W = 29;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        COMMIT    = 2'd2,
        WAIT_BANK = 2'd3
    } loader_state_t;

    function automatic logic [FFT_SIZE-1:0] bitrev(input logic [FFT_SIZE-1:0] a);
        logic [FFT_SIZE-1:0] r;
        for (int i = 0; i < FFT_SIZE; i++) begin
            r[i] = a[FFT_SIZE-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational address reversal; EN=0 passes the address through so DIF builds keep natural order.
module fft_bitrev #(
    parameter int SIZE = 4,
    parameter bit EN   = 1'b1
) (
    input  logic [SIZE-1:0] addr_in,
    output logic [SIZE-1:0] addr_out
);

    logic [SIZE-1:0] addr_rev;

    for (genvar i = 0; i < SIZE; i++) begin : g_rev
        assign addr_rev[i] = addr_in[SIZE-1-i];
    end

    assign addr_out = EN ? addr_rev : addr_in;

endmodule

// File: rtl/fft_input_loader.sv
// Ping-pong frame loader for the stage-1 sample RAM.
// Define FFT_LOADER_BITREV_EN for bit-reversed write addresses (DIT); natural order otherwise.
//
//   state     | meaning
//   IDLE      | one cycle after reset, not ready
//   LOAD      | accepting samples into cur_bank
//   COMMIT    | mark cur_bank full, flip banks, pulse frame_rdy
//   WAIT_BANK | next bank still held downstream, stalled
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N,
    parameter int SIZE   = FFT_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [SIZE-1:0]   wr_addr,
    output logic [DATA_W-1:0] wr_re,
    output logic [DATA_W-1:0] wr_im,
    output logic              frame_rdy,
    output logic              frame_bank,
    input  logic              rd_done,
    input  logic              rd_bank,
    output logic              frame_err
);

`ifdef FFT_LOADER_BITREV_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    loader_state_t   state, state_nxt;
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] addr;
    logic            cur_bank;
    logic [1:0]      full, full_nxt;
    logic            accept;
    logic            cnt_last;
    logic            commit;

    assign accept   = in_valid && in_ready;
    assign cnt_last = (cnt == SIZE'(N - 1));

    fft_bitrev #(.SIZE(SIZE), .EN(REV_EN)) u_bitrev (
        .addr_in  (cnt),
        .addr_out (addr)
    );

    // Release first, then commit, so a same-bank collision leaves the bank full.
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (commit)  full_nxt[cur_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = LOAD;
            LOAD:      if (accept && cnt_last) state_nxt = COMMIT;
            COMMIT:    state_nxt = full_nxt[~cur_bank] ? WAIT_BANK : LOAD;
            WAIT_BANK: if (!full_nxt[cur_bank]) state_nxt = LOAD;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        commit   = 1'b0;
        case (state)
            LOAD:    in_ready = 1'b1;
            COMMIT:  commit   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            cur_bank   <= 1'b0;
            full       <= 2'b00;
            wr_en      <= 1'b0;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            wr_re      <= '0;
            wr_im      <= '0;
            frame_rdy  <= 1'b0;
            frame_bank <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            full      <= full_nxt;
            wr_en     <= accept;
            frame_rdy <= commit;
            frame_err <= accept && (in_last != cnt_last);
            if (accept) begin
                wr_addr <= addr;
                wr_bank <= cur_bank;
                wr_re   <= in_re;
                wr_im   <= in_im;
                // Early in_last abandons the partial frame and restarts the same bank.
                cnt     <= (in_last && !cnt_last) ? '0 : cnt + 1'b1;
            end
            if (commit) begin
                cur_bank   <= ~cur_bank;
                frame_bank <= cur_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed self-checking bench for fft_input_loader; follows FFT_LOADER_BITREV_EN for address expectations.
module tb_fft_input_loader;
    import fft_pkg::*;

    localparam int DW = FFT_DATA_W;
    localparam int SW = FFT_SIZE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_re, in_im;
    logic          in_last;
    logic          in_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [SW-1:0] wr_addr;
    logic [DW-1:0] wr_re, wr_im;
    logic          frame_rdy;
    logic          frame_bank;
    logic          rd_done;
    logic          rd_bank;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_input_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_re      (wr_re),
        .wr_im      (wr_im),
        .frame_rdy  (frame_rdy),
        .frame_bank (frame_bank),
        .rd_done    (rd_done),
        .rd_bank    (rd_bank),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(input int k);
`ifdef FFT_LOADER_BITREV_EN
        return br_tab[k];
`else
        return k;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_re"}, 32'(wr_re), 0);
        chk({tag, "_wr_im"}, 32'(wr_im), 0);
        chk({tag, "_frame_rdy"}, 32'(frame_rdy), 0);
        chk({tag, "_frame_bank"}, 32'(frame_bank), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
    endtask

    // One accepted sample at index k; checks the registered write one cycle later.
    task automatic accept_one(input int k, input int val, input logic last,
                              input logic bank, input logic err);
        logic [DW-1:0] er, ei;
        er = DW'(val);
        ei = DW'(-val);
        in_valid = 1'b1;
        in_re    = er;
        in_im    = ei;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("wr_en", 32'(wr_en), 1);
        chk("wr_addr", 32'(wr_addr), 32'(exp_addr(k)));
        chk("wr_bank", 32'(wr_bank), 32'(bank));
        chk("wr_re", 32'(wr_re), 32'(er));
        chk("wr_im", 32'(wr_im), 32'(ei));
        chk("frame_err", 32'(frame_err), 32'(err));
    endtask

    // Back-to-back full frame; returns in the COMMIT cycle.
    task automatic send_frame(input logic bank, input int base, input logic with_last);
        chk("frame_ready_start", 32'(in_ready), 1);
        for (int k = 0; k < 16; k++) begin
            accept_one(k, base + k, with_last && (k == 15), bank, (k == 15) && !with_last);
            if (k < 15) chk("ready_in_frame", 32'(in_ready), 1);
        end
        chk("ready_commit", 32'(in_ready), 0);
        chk("frame_rdy_early", 32'(frame_rdy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("idle_ready", 32'(in_ready), 0);
        step();
        chk("load_ready", 32'(in_ready), 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        in_last  = 1'b0;
        rd_done  = 1'b0;
        rd_bank  = 1'b0;
        #1;
        check_all_zero("rst");
        do_reset();

        // Frame A into bank 0
        send_frame(1'b0, 0, 1'b1);
        step();
        chk("a_frame_rdy", 32'(frame_rdy), 1);
        chk("a_frame_bank", 32'(frame_bank), 0);
        chk("a_ready_after", 32'(in_ready), 1);
        chk("a_wr_en_bubble", 32'(wr_en), 0);

        // Frame B into bank 1, both banks now held
        send_frame(1'b1, 100, 1'b1);
        step();
        chk("b_frame_rdy", 32'(frame_rdy), 1);
        chk("b_frame_bank", 32'(frame_bank), 1);
        chk("b_wait_ready", 32'(in_ready), 0);
        step();
        chk("b_wait_ready2", 32'(in_ready), 0);
        chk("b_frame_rdy_pulse", 32'(frame_rdy), 0);
        rd_done = 1'b1;
        rd_bank = 1'b0;
        step();
        rd_done = 1'b0;
        chk("b_release_ready", 32'(in_ready), 1);

        // Frame C into bank 0; bank 1 released during C's COMMIT
        send_frame(1'b0, 200, 1'b1);
        rd_done = 1'b1;
        rd_bank = 1'b1;
        step();
        rd_done = 1'b0;
        chk("c_frame_rdy", 32'(frame_rdy), 1);
        chk("c_frame_bank", 32'(frame_bank), 0);
        chk("c_no_wait_ready", 32'(in_ready), 1);
        accept_one(0, 300, 1'b0, 1'b1, 1'b0);

        // Early in_last at index 5
        do_reset();
        for (int k = 0; k < 6; k++) accept_one(k, 10 + k, k == 5, 1'b0, k == 5);
        step();
        chk("early_err_pulse", 32'(frame_err), 0);
        chk("early_no_rdy", 32'(frame_rdy), 0);
        chk("early_ready", 32'(in_ready), 1);
        step();
        chk("early_no_rdy2", 32'(frame_rdy), 0);
        accept_one(0, 50, 1'b0, 1'b0, 1'b0);

        // Frame without in_last: error at index 15, still commits bank 0
        do_reset();
        send_frame(1'b0, 400, 1'b0);
        step();
        chk("nolast_frame_rdy", 32'(frame_rdy), 1);
        chk("nolast_frame_bank", 32'(frame_bank), 0);
        chk("nolast_err_cleared", 32'(frame_err), 0);

        // in_valid toggling across part of a frame in bank 1, then async reset
        for (int k = 0; k < 7; k++) begin
            accept_one(k, 500 + k, 1'b0, 1'b1, 1'b0);
            if (k < 6) begin
                step();
                chk("gap_no_wr_en", 32'(wr_en), 0);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_idle", 32'(in_ready), 0);
        step();
        chk("post_rst_load", 32'(in_ready), 1);
        accept_one(0, 77, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
